// File: rtl/vend_dispenser.sv
// Vend event dispenser: buffers soda/change events, pulses the solenoid, then ejects nickels over req/ack.
// Optional per-event statistics counters are enabled with VEND_DISPENSER_STATS_EN.
module vend_dispenser #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SOL_CYCLES = 4,
  parameter int unsigned COIN_GAP   = 2
) (
  input  logic                          i_clk,
  input  logic                          reset_n,
  input  logic                          i_soda,
  input  logic [2:0]                    i_change,
  input  logic                          i_eject_ack,
  output logic                          o_solenoid,
  output logic                          o_eject_req,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_pending,
  output logic                          o_overflow,
`ifdef VEND_DISPENSER_STATS_EN
  output logic [15:0]                   o_soda_cnt,
  output logic [15:0]                   o_nickel_cnt,
`endif
  output logic                          o_err
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned SCW = (SOL_CYCLES > 1) ? $clog2(SOL_CYCLES + 1) : 1;
  localparam int unsigned GCW = (COIN_GAP > 1) ? $clog2(COIN_GAP + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SOL      = 2'd1,
    S_COIN_REQ = 2'd2,
    S_COIN_GAP = 2'd3
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     rem, rem_nx;
  logic [SCW-1:0] sol_cnt, sol_nx;
  logic [GCW-1:0] gap_cnt, gap_nx;
  logic           req_nx;
  logic           pop, push, ack_ok;
  logic           fifo_empty, fifo_full;
  logic [2:0]     chg_clamped;
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [2:0]     mem [FIFO_DEPTH];

  // Event FIFO status; the pop never bypasses a same-edge push
  assign fifo_empty  = (o_pending == '0);
  assign fifo_full   = (o_pending == CW'(FIFO_DEPTH));
  assign chg_clamped = (i_change > 3'd4) ? 3'd4 : i_change;
  assign push        = i_soda && (!fifo_full || pop);
  assign ack_ok      = o_eject_req && i_eject_ack;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= chg_clamped;
  end

  // Next-state and output decode
  always_comb begin
    state_nx = state;
    rem_nx   = rem;
    sol_nx   = sol_cnt;
    gap_nx   = gap_cnt;
    req_nx   = o_eject_req;
    pop      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          rem_nx   = mem[rd_ptr];
          sol_nx   = SCW'(SOL_CYCLES);
          state_nx = S_SOL;
        end
      end
      S_SOL: begin
        if (sol_cnt == SCW'(1)) begin
          if (rem != 3'd0) begin
            state_nx = S_COIN_REQ;
            req_nx   = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          sol_nx = sol_cnt - SCW'(1);
        end
      end
      S_COIN_REQ: begin
        if (ack_ok) begin
          rem_nx = rem - 3'd1;
          req_nx = 1'b0;
          if (rem == 3'd1) begin
            state_nx = S_IDLE;
          end else if (COIN_GAP > 0) begin
            state_nx = S_COIN_GAP;
            gap_nx   = GCW'(COIN_GAP);
          end
        end else if (!o_eject_req) begin
          // back-to-back mode: one forced low cycle has elapsed
          req_nx = 1'b1;
        end
      end
      S_COIN_GAP: begin
        if (gap_cnt <= GCW'(1)) begin
          state_nx = S_COIN_REQ;
          req_nx   = 1'b1;
        end else begin
          gap_nx = gap_cnt - GCW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // State, FIFO bookkeeping and registered outputs
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      rem         <= '0;
      sol_cnt     <= '0;
      gap_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      o_pending   <= '0;
      o_solenoid  <= 1'b0;
      o_eject_req <= 1'b0;
      o_busy      <= 1'b0;
      o_overflow  <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      state       <= state_nx;
      rem         <= rem_nx;
      sol_cnt     <= sol_nx;
      gap_cnt     <= gap_nx;
      o_solenoid  <= (state_nx == S_SOL);
      o_eject_req <= req_nx;
      o_busy      <= (state != S_IDLE) || !fifo_empty;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      o_pending <= o_pending + CW'(1);
      else if (pop && !push) o_pending <= o_pending - CW'(1);
      if (i_soda && fifo_full && !pop) o_overflow <= 1'b1;
      if (i_soda && (i_change > 3'd4)) o_err      <= 1'b1;
    end
  end

`ifdef VEND_DISPENSER_STATS_EN
  // Free-running event counters, wrapping naturally at 16 bits
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      o_soda_cnt   <= '0;
      o_nickel_cnt <= '0;
    end else begin
      if (pop)    o_soda_cnt   <= o_soda_cnt + 16'd1;
      if (ack_ok) o_nickel_cnt <= o_nickel_cnt + 16'd1;
    end
  end
`endif

endmodule
